pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 21 ++
 rtl/pipelined_adder_slice.sv | 25 ++
 rtl/pipelined_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and configuration helpers for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits handled by each pipeline slice.
  function automatic int calc_chunk(input int width, input int stages);
    if (stages > 0) begin
      return width / stages;
    end else begin
      return 0;
    end
  endfunction

  // A legal configuration splits WIDTH into equal, non-empty slices.
  function automatic bit config_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: W-bit combinational ripple-carry adder, one per pipeline stage.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry_s;

  // Ripple the carry bit by bit from cin up to cout.
  always_comb begin
    carry_s = cin;
    sum     = '0;
    for (int i = 0; i < W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    cout = carry_s;
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES carry-pipelined slices
// with a valid/ready handshake on both sides.
// Optional feature: define PIPELINED_ADDER_OVERFLOW_EN to add the registered
// signed-overflow output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout
);

  localparam int CHUNK = calc_chunk(WIDTH, STAGES);

  if (!config_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  // Stage registers: operands travel with the transaction so later stages can
  // consume their upper slices; sum_r accumulates completed lower slices.
  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  sum_r [STAGES];

  // Per-stage inputs (previous stage register, or the input port for stage 0).
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] src_valid_s;
  logic [STAGES-1:0] src_carry_s;
  logic [WIDTH-1:0]  src_a_s   [STAGES];
  logic [WIDTH-1:0]  src_b_s   [STAGES];
  logic [WIDTH-1:0]  src_sum_s [STAGES];
  logic [CHUNK-1:0]  slice_sum_s [STAGES];
  logic [STAGES-1:0] slice_cout_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k may load when out_ready or any stage from k onward is empty.
    assign adv_s[k] = out_ready | ~(&valid_r[STAGES-1:k]);

    if (k == 0) begin : g_first
      assign src_valid_s[k] = in_valid;
      assign src_carry_s[k] = cin;
      assign src_a_s[k]     = a;
      assign src_b_s[k]     = b;
      assign src_sum_s[k]   = '0;
    end else begin : g_next
      assign src_valid_s[k] = valid_r[k-1];
      assign src_carry_s[k] = carry_r[k-1];
      assign src_a_s[k]     = a_r[k-1];
      assign src_b_s[k]     = b_r[k-1];
      assign src_sum_s[k]   = sum_r[k-1];
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a    (src_a_s[k][k*CHUNK +: CHUNK]),
      .b    (src_b_s[k][k*CHUNK +: CHUNK]),
      .cin  (src_carry_s[k]),
      .sum  (slice_sum_s[k]),
      .cout (slice_cout_s[k])
    );
  end

  // Advance every stage that has room; data only updates on real transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      carry_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          valid_r[k] <= src_valid_s[k];
          if (src_valid_s[k]) begin
            a_r[k]   <= src_a_s[k];
            b_r[k]   <= src_b_s[k];
            carry_r[k] <= slice_cout_s[k];
            sum_r[k] <= src_sum_s[k];
            sum_r[k][k*CHUNK +: CHUNK] <= slice_sum_s[k];
          end
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_r;

  // Signed overflow, computed as the top slice lands so it stays aligned with sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (adv_s[STAGES-1] && src_valid_s[STAGES-1]) begin
      ovf_r <= (src_a_s[STAGES-1][WIDTH-1] == src_b_s[STAGES-1][WIDTH-1]) &&
               (slice_sum_s[STAGES-1][CHUNK-1] != src_a_s[STAGES-1][WIDTH-1]);
    end
  end

  assign overflow = ovf_r;
`endif

  // The last stage's operand copies are never consumed downstream.
  logic unused_s;
  assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1]};

  assign in_ready  = adv_s[0];
  assign out_valid = valid_r[STAGES-1];
  assign sum       = sum_r[STAGES-1];
  assign cout      = carry_r[STAGES-1];

endmodule
